// File: rtl/dm_access_unit.sv
// Load/store initiator for the word-addressed data memory: byte/half read-modify-write and load extension.
// Optional macro LSU_ALIGN_CHECK_EN rejects misaligned half/word requests.
module dm_access_unit #(
  parameter int unsigned MEM_BYTES = 12288
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wren,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_pc
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state, state_nxt;
  logic        we_q, sgn_q, err_q, req_err;
  logic [1:0]  size_q, lane_q;
  logic [31:0] wdata_q, rbuf, merged, load_data;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    req_err = (req_size == 2'b11) || (req_addr >= 32'(MEM_BYTES));
`ifdef LSU_ALIGN_CHECK_EN
    if (req_size == 2'b01 && req_addr[0])         req_err = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00) req_err = 1'b1;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                              state_nxt = RESP;
          else if (!req_we || req_size != 2'b10)    state_nxt = READ;
          else                                      state_nxt = WRITE;
        end
      end
      READ:    state_nxt = we_q ? WRITE : RESP;
      WRITE:   state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      we_q     <= 1'b0;
      sgn_q    <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= 2'b00;
      lane_q   <= 2'b00;
      wdata_q  <= 32'h0;
      rbuf     <= 32'h0;
      mem_addr <= 32'h0;
      mem_pc   <= 32'h0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        we_q     <= req_we;
        sgn_q    <= req_signed;
        err_q    <= req_err;
        size_q   <= req_size;
        lane_q   <= req_addr[1:0];
        wdata_q  <= req_wdata;
        mem_addr <= {req_addr[31:2], 2'b00};
        mem_pc   <= req_pc;
      end
      if (state == READ) rbuf <= mem_rdata;
    end
  end

  always_comb begin
    merged = rbuf;
    case (size_q)
      2'b00:   merged[{lane_q, 3'b000} +: 8]     = wdata_q[7:0];
      2'b01:   merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  assign lane_byte = rbuf[{lane_q, 3'b000} +: 8];
  assign lane_half = rbuf[{lane_q[1], 4'b0000} +: 16];

  always_comb begin
    case (size_q)
      2'b00:   load_data = sgn_q ? {{24{lane_byte[7]}}, lane_byte} : {24'h0, lane_byte};
      2'b01:   load_data = sgn_q ? {{16{lane_half[15]}}, lane_half} : {16'h0, lane_half};
      default: load_data = rbuf;
    endcase
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_err   = (state == RESP) && err_q;
  assign rsp_rdata = (state == RESP && !err_q && !we_q) ? load_data : 32'h0;
  // Gating with reset drops a write whose cycle coincides with reset.
  assign mem_wren  = (state == WRITE) && !reset;
  assign mem_wdata = (state == WRITE) ? merged : 32'h0;

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed, table-driven bench for dm_access_unit with a behavioural data memory.
module tb_dm_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic        rsp_valid, rsp_err, mem_wren;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata, mem_pc;

  logic [31:0] mem [0:3071];

  int tests = 0;
  int failed = 0;

  dm_access_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_rdata(mem_rdata), .mem_pc(mem_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_wren && mem_addr < 32'd12288) mem[mem_addr[13:2]] <= mem_wdata;

  assign mem_rdata = (mem_addr < 32'd12288) ? mem[mem_addr[13:2]] : 32'h0;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic we, logic [1:0] sz, logic sg, logic [31:0] a,
                              logic [31:0] wd, logic [31:0] rd, logic er, int lt, int w);
    vec_t v;
    v.name = n; v.we = we; v.size = sz; v.sgn = sg; v.addr = a; v.wdata = wd;
    v.rdata = rd; v.err = er; v.lat = lt; v.wr = w;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input logic [31:0] pc);
    int n = 0;
    int wr_cnt = 0;
    int lat = 0;
    logic [31:0] rd = 32'h0, pcv = 32'h0;
    logic er = 1'b0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk({v.name, "_ready_timeout"}, 32'(req_ready), 32'h1);
      return;
    end
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_signed = v.sgn;
    req_addr = v.addr; req_wdata = v.wdata; req_pc = pc;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (mem_wren) wr_cnt++;
      if (rsp_valid) begin
        lat = k; rd = rsp_rdata; er = rsp_err; pcv = mem_pc;
        break;
      end
      @(negedge clk);
    end
    if (lat == 0) begin
      chk({v.name, "_rsp_timeout"}, 32'(rsp_valid), 32'h1);
      return;
    end
    chk({v.name, "_lat"}, 32'(lat), 32'(v.lat));
    chk({v.name, "_rdata"}, rd, v.rdata);
    chk({v.name, "_err"}, 32'(er), 32'(v.err));
    chk({v.name, "_wren_cnt"}, 32'(wr_cnt), 32'(v.wr));
    chk({v.name, "_pc"}, pcv, pc);
    @(negedge clk);
    chk({v.name, "_pulse_end"}, {30'h0, rsp_valid, req_ready}, 32'h1);
  endtask

  initial begin
    for (int i = 0; i < 3072; i++) mem[i] = 32'h0;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; req_pc = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h1);
    chk("rst_rsp", {29'h0, rsp_valid, rsp_err, mem_wren}, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_pc", mem_pc, 32'h0);
    reset = 1'b0;

    vecs.push_back(mk("sw10",     1, 2'b10, 0, 32'h10,   32'hDEADBEEF, 32'h0,        0, 2, 1));
    vecs.push_back(mk("lw10",     0, 2'b10, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0, 2, 0));
    vecs.push_back(mk("sw20",     1, 2'b10, 0, 32'h20,   32'h11223344, 32'h0,        0, 2, 1));
    vecs.push_back(mk("sb22",     1, 2'b00, 0, 32'h22,   32'h000000AA, 32'h0,        0, 3, 1));
    vecs.push_back(mk("lw20_a",   0, 2'b10, 0, 32'h20,   32'h0,        32'h11AA3344, 0, 2, 0));
    vecs.push_back(mk("lb22",     0, 2'b00, 1, 32'h22,   32'h0,        32'hFFFFFFAA, 0, 2, 0));
    vecs.push_back(mk("lbu22",    0, 2'b00, 0, 32'h22,   32'h0,        32'h000000AA, 0, 2, 0));
    vecs.push_back(mk("lh22",     0, 2'b01, 1, 32'h22,   32'h0,        32'h000011AA, 0, 2, 0));
    vecs.push_back(mk("sh20",     1, 2'b01, 0, 32'h20,   32'hFFFF8001, 32'h0,        0, 3, 1));
    vecs.push_back(mk("lh20",     0, 2'b01, 1, 32'h20,   32'h0,        32'hFFFF8001, 0, 2, 0));
    vecs.push_back(mk("lhu20",    0, 2'b01, 0, 32'h20,   32'h0,        32'h00008001, 0, 2, 0));
    vecs.push_back(mk("lb23",     0, 2'b00, 1, 32'h23,   32'h0,        32'h00000011, 0, 2, 0));
    vecs.push_back(mk("lb20",     0, 2'b00, 1, 32'h20,   32'h0,        32'h00000001, 0, 2, 0));
    vecs.push_back(mk("lb21",     0, 2'b00, 1, 32'h21,   32'h0,        32'hFFFFFF80, 0, 2, 0));
    vecs.push_back(mk("sb23",     1, 2'b00, 0, 32'h23,   32'h123456FE, 32'h0,        0, 3, 1));
    vecs.push_back(mk("lw20_b",   0, 2'b10, 0, 32'h20,   32'h0,        32'hFEAA8001, 0, 2, 0));
    vecs.push_back(mk("ld_sz11",  0, 2'b11, 0, 32'h10,   32'h0,        32'h0,        1, 1, 0));
    vecs.push_back(mk("st_sz11",  1, 2'b11, 0, 32'h10,   32'h55555555, 32'h0,        1, 1, 0));
    vecs.push_back(mk("sw3000",   1, 2'b10, 0, 32'h3000, 32'h12345678, 32'h0,        1, 1, 0));
    vecs.push_back(mk("lw3000",   0, 2'b10, 0, 32'h3000, 32'h0,        32'h0,        1, 1, 0));
    vecs.push_back(mk("sw2ffc",   1, 2'b10, 0, 32'h2FFC, 32'h12345678, 32'h0,        0, 2, 1));
    vecs.push_back(mk("lw2ffc",   0, 2'b10, 0, 32'h2FFC, 32'h0,        32'h12345678, 0, 2, 0));
    vecs.push_back(mk("lw10_b",   0, 2'b10, 0, 32'h10,   32'h0,        32'hDEADBEEF, 0, 2, 0));
`ifdef LSU_ALIGN_CHECK_EN
    vecs.push_back(mk("sw21",     1, 2'b10, 0, 32'h21,   32'hCAFEF00D, 32'h0,        1, 1, 0));
    vecs.push_back(mk("lw20_c",   0, 2'b10, 0, 32'h20,   32'h0,        32'hFEAA8001, 0, 2, 0));
    vecs.push_back(mk("lh21",     0, 2'b01, 1, 32'h21,   32'h0,        32'h0,        1, 1, 0));
`else
    vecs.push_back(mk("sw21",     1, 2'b10, 0, 32'h21,   32'hCAFEF00D, 32'h0,        0, 2, 1));
    vecs.push_back(mk("lw20_c",   0, 2'b10, 0, 32'h20,   32'h0,        32'hCAFEF00D, 0, 2, 0));
    vecs.push_back(mk("lh21",     0, 2'b01, 1, 32'h21,   32'h0,        32'hFFFFF00D, 0, 2, 0));
`endif

    foreach (vecs[i]) run_vec(vecs[i], 32'h1000 + 32'(i) * 4);

    // Reset lands on the WRITE cycle of a byte store: the write and response must vanish.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h11; req_wdata = 32'h00000055; req_pc = 32'h2000;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rstmid_read_wren", 32'(mem_wren), 32'h0);
    @(negedge clk);
    chk("rstmid_write_wren_pre", 32'(mem_wren), 32'h1);
    reset = 1'b1;
    #1;
    chk("rstmid_write_wren", 32'(mem_wren), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    chk("rstmid_ready", 32'(req_ready), 32'h1);
    chk("rstmid_no_rsp", 32'(rsp_valid), 32'h0);
    begin
      int seen = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (rsp_valid || mem_wren) seen++;
      end
      chk("rstmid_quiet", 32'(seen), 32'h0);
    end
    chk("rstmid_mem", mem[4], 32'hDEADBEEF);
    run_vec(mk("lw10_c", 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 2, 0), 32'h3000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
